mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder that services the load/store memory requests issued by the CPU datapath (read_mem/write_mem with the MAR address and MDR store data). It models a RAM with configurable access latency and answers each request with a one-cycle ready pulse. It sits between the datapath's MAR/MDR and the memory array. It lets multi-cycle memory be exercised by the control sequence instead of relying on zero-latency combinational reads.

## Interface
- DEPTH, 512: number of 32-bit words; must be a power of two.
- AW, 9: address bits used, log2(DEPTH).
- LAT, 2: access latency in cycles from request acceptance to ready; legal range 1..15.
- INIT_FILE, "": optional hex image loaded into the array at elaboration; empty means the array is uninitialised.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- read_mem  in  1  read request level; held by the requester until mem_ready.
- write_mem  in  1  write request level; held by the requester until mem_ready.
- addr  in  32  word address from MAR; only addr[AW-1:0] is used.
- wdata  in  32  store data from MDR.
- rdata  out  32  read data, registered; feeds the MDR input mux.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high whenever the state is not IDLE.
- cmd_err  out  1  one-cycle pulse when read_mem and write_mem are both high at acceptance.

## Operation
- States are IDLE, ACCESS, DONE and HOLD. A 4-bit latency counter `cnt` is used.
- IDLE: if read_mem or write_mem is high at a rising edge, the request is accepted:
  - Latch addr[AW-1:0], wdata and op into internal registers. Write wins when both requests are high, and cmd_err pulses.
  - Load cnt = LAT-1 and go to ACCESS.
- ACCESS: the latched address and data are used, so later changes on addr and wdata are ignored.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: perform the access and go to DONE.
    - Read: rdata <= mem[addr_q].
    - Write: mem[addr_q] <= wdata_q, and rdata is unchanged.
- DONE: mem_ready = 1 for exactly this cycle.
  - Next state is HOLD if read_mem or write_mem is still high, else IDLE.
- HOLD: wait until both read_mem and write_mem are low, then go to IDLE.
  - This prevents a request level that is still held from re-triggering an access.
  - Nothing is accepted in HOLD.
- Address upper bits addr[31:AW] are ignored, so accesses wrap modulo DEPTH with no error.
- rdata holds its last read value through writes and idle periods.
- Reset (low, asynchronous):
  - State goes to IDLE, cnt = 0, rdata = 0, mem_ready = 0, busy = 0, cmd_err = 0.
  - Array contents are NOT cleared.
  - A write in ACCESS aborted by reset before its cnt == 0 edge does not modify the array.
- Requests asserted while reset is low are ignored. They are accepted at the first rising edge after reset releases, if still high.

## Timing
- Request sampled high at edge E0 (IDLE): after E0, busy = 1.
- Access happens at edge E0+LAT. mem_ready and the new rdata are visible after E0+LAT and remain valid until E0+LAT+1.
- mem_ready falls after E0+LAT+1.
- busy falls after E0+LAT+1 if the request dropped in the ready cycle. Otherwise it falls one edge after the request drops (HOLD).
- Minimum back-to-back spacing is LAT+2 cycles: a new request is accepted at the first IDLE edge.
- A read following a write to the same address returns the new data, because the write commits before the read is accepted.
- cmd_err is visible for the one cycle following E0.
- The requester may drop its request early (before mem_ready). The access still completes, mem_ready still pulses, and DONE goes straight to IDLE.

## Test plan
- Read with LAT=2: preload mem[5]=0x0000_00A5; hold read_mem with addr=5 from edge E0 -> mem_ready high only in cycle E0+2..E0+3; rdata=0x0000_00A5; busy low after request drop.
- Store then load: write_mem with addr=0x87, wdata=0x1234_5678, then read_mem with addr=0x87 -> rdata=0x1234_5678; spacing of LAT+2 cycles accepted, and one cycle earlier is not accepted.
- Held request (4-phase): keep read_mem high 6 cycles after mem_ready -> exactly one mem_ready pulse; state in HOLD; next access only after read_mem low for ≥1 edge.
- Simultaneous requests: read_mem=write_mem=1, addr=3, wdata=0xDEAD_BEEF -> cmd_err pulses one cycle; mem[3]=0xDEAD_BEEF; rdata unchanged.
- Wrap and latency sweep: addr=0x0000_0205 with DEPTH=512 accesses word 5; repeat with LAT=1 and LAT=15 -> ready is exactly LAT edges after acceptance.
- Reset mid-write: LAT=4, write 0xFFFF_FFFF to addr 9 (old value 0x11); assert reset after 2 cycles -> all outputs 0 immediately; mem[9] still reads 0x11 after reset release.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath's MAR/MDR and the memory responder.
// The master issues read/write request levels; the slave answers with a ready pulse.
interface mem_responder_if;
    logic        read_mem;
    logic        write_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        busy;
    logic        cmd_err;

    modport master (
        output read_mem, write_mem, addr, wdata,
        input  rdata, mem_ready, busy, cmd_err
    );

    modport slave (
        input  read_mem, write_mem, addr, wdata,
        output rdata, mem_ready, busy, cmd_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with a fixed access latency and a one-cycle ready pulse.
// A four-phase request level is latched in IDLE, serviced after LAT edges, then released via HOLD.
module mem_responder #(
    parameter int    DEPTH     = 512,
    parameter int    AW        = 9,
    parameter int    LAT       = 2,
    parameter string INIT_FILE = ""
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic [3:0]    cnt_next;
    logic          req;
    logic          accept;
    logic          do_access;

    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          write_q;
    logic [31:0]   rdata_q;
    logic          cmd_err_q;

    logic [31:0]   mem [DEPTH];

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH.
    logic          unused_addr;
    assign unused_addr = ^bus.addr[31:AW];

    assign req = bus.read_mem | bus.write_mem;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    do_access  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = req ? HOLD : IDLE;
            end
            HOLD: begin
                // A still-held level must drop before another access can start.
                if (!req) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request capture: later changes on addr/wdata during ACCESS are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= bus.addr[AW-1:0];
            wdata_q <= bus.wdata;
            write_q <= bus.write_mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q   <= 32'd0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= accept & bus.read_mem & bus.write_mem;
            if (do_access && !write_q) rdata_q <= mem[addr_q];
        end
    end

    // The array is never cleared; a reset during ACCESS forces IDLE so the write never commits.
    always_ff @(posedge clk) begin
        if (do_access && write_q) mem[addr_q] <= wdata_q;
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances with LAT = 2, 1, 15, 4 share clock and reset.
// Expected read data comes from a word model per instance, queued at request time.
module tb_mem_responder;

    localparam int NI = 4;
    localparam int LATS [NI] = '{2, 1, 15, 4};

    typedef struct {
        int          idx;
        logic [31:0] rdata;
    } sb_t;

    logic clk;
    logic rst_n;

    logic [NI-1:0]       rd;
    logic [NI-1:0]       wr;
    logic [NI-1:0][31:0] ad;
    logic [NI-1:0][31:0] wd;
    logic [NI-1:0][31:0] o_rdata;
    logic [NI-1:0]       o_ready;
    logic [NI-1:0]       o_busy;
    logic [NI-1:0]       o_err;

    logic [31:0] model   [NI][512];
    logic [31:0] last_rd [NI];
    sb_t         sb [$];

    int n_vec;
    int n_err;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder_if bus ();
        assign bus.read_mem  = rd[g];
        assign bus.write_mem = wr[g];
        assign bus.addr      = ad[g];
        assign bus.wdata     = wd[g];
        assign o_rdata[g]    = bus.rdata;
        assign o_ready[g]    = bus.mem_ready;
        assign o_busy[g]     = bus.busy;
        assign o_err[g]      = bus.cmd_err;

        mem_responder #(.DEPTH(512), .AW(9), .LAT(LATS[g]), .INIT_FILE("")) dut (
            .clk   (clk),
            .reset (rst_n),
            .bus   (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // hold > 0: keep the request that many cycles past mem_ready; hold < 0: drop right after acceptance.
    task automatic do_access(input int idx, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d, input int hold);
        sb_t         it;
        int          n;
        logic [31:0] exp_rd;
        @(negedge clk);
        rd[idx] = r;
        wr[idx] = w;
        ad[idx] = a;
        wd[idx] = d;
        if (w) begin
            model[idx][a[8:0]] = d;
            exp_rd = last_rd[idx];
        end else begin
            exp_rd = model[idx][a[8:0]];
        end
        last_rd[idx] = exp_rd;
        sb.push_back('{idx, exp_rd});
        @(posedge clk); #1;
        chk("busy_accept", 32'(o_busy[idx]), 32'd1);
        chk("cmd_err_pulse", 32'(o_err[idx]), 32'(r & w));
        if (hold < 0) begin
            rd[idx] = 1'b0;
            wr[idx] = 1'b0;
        end
        n = 0;
        while (!o_ready[idx] && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk("cmd_err_clear", 32'(o_err[idx]), 32'd0);
        end
        chk("ready_latency", 32'(n), 32'(LATS[idx]));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            it = sb.pop_front();
            chk("rdata", o_rdata[it.idx], it.rdata);
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_no_ready", 32'(o_ready[idx]), 32'd0);
                chk("hold_busy", 32'(o_busy[idx]), 32'd1);
            end
        end
        @(negedge clk);
        rd[idx] = 1'b0;
        wr[idx] = 1'b0;
        @(posedge clk); #1;
        chk("ready_fall", 32'(o_ready[idx]), 32'd0);
        chk("busy_fall", 32'(o_busy[idx]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        rd    = '0;
        wr    = '0;
        ad    = '0;
        wd    = '0;
        for (int i = 0; i < NI; i++) last_rd[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_rdata", o_rdata[i], 32'd0);
            chk("rst_ready", 32'(o_ready[i]), 32'd0);
            chk("rst_busy", 32'(o_busy[i]), 32'd0);
            chk("rst_cmd_err", 32'(o_err[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // LAT=2: preload word 5, read it back, then store/load at 0x87.
        do_access(0, 1'b0, 1'b1, 32'h5, 32'h0000_00A5, 0);
        do_access(0, 1'b1, 1'b0, 32'h5, 32'h0, 0);
        do_access(0, 1'b0, 1'b1, 32'h87, 32'h1234_5678, 0);
        do_access(0, 1'b1, 1'b0, 32'h87, 32'h0, 0);

        // Held read: one pulse only, HOLD until the level drops.
        do_access(0, 1'b1, 1'b0, 32'h5, 32'h0, 6);

        // Simultaneous requests: write wins, rdata untouched, then confirm the stored word.
        do_access(0, 1'b1, 1'b1, 32'h3, 32'hDEAD_BEEF, 0);
        do_access(0, 1'b1, 1'b0, 32'h3, 32'h0, 0);

        // Early drop: access still completes with a ready pulse.
        do_access(0, 1'b1, 1'b0, 32'h87, 32'h0, -1);

        // A read raised during the ready cycle of a write is not accepted.
        @(negedge clk);
        wr[0] = 1'b1;
        ad[0] = 32'h40;
        wd[0] = 32'h0000_0055;
        model[0][9'h40] = 32'h0000_0055;
        @(posedge clk);
        repeat (LATS[0]) @(posedge clk);
        #1;
        chk("early_wr_ready", 32'(o_ready[0]), 32'd1);
        @(negedge clk);
        wr[0] = 1'b0;
        rd[0] = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_ready[0]) pulses++;
        end
        chk("early_rd_not_accepted", 32'(pulses), 32'd0);
        chk("early_rd_hold_busy", 32'(o_busy[0]), 32'd1);
        @(negedge clk);
        rd[0] = 1'b0;
        @(posedge clk); #1;
        chk("early_rd_idle", 32'(o_busy[0]), 32'd0);
        do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, 0);

        // Address wrap with LAT=1 and LAT=15.
        do_access(1, 1'b0, 1'b1, 32'h0000_0205, 32'hCAFE_0001, 0);
        do_access(1, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 0);
        do_access(2, 1'b0, 1'b1, 32'h0000_0205, 32'hCAFE_0015, 0);
        do_access(2, 1'b1, 1'b0, 32'hFFFF_FE05, 32'h0, 0);

        // LAT=4: reset aborts a write in flight without touching the array.
        do_access(3, 1'b0, 1'b1, 32'h9, 32'h0000_0011, 0);
        do_access(3, 1'b1, 1'b0, 32'h9, 32'h0, 0);
        @(negedge clk);
        wr[3] = 1'b1;
        ad[3] = 32'h9;
        wd[3] = 32'hFFFF_FFFF;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rdata", o_rdata[3], 32'd0);
        chk("abort_ready", 32'(o_ready[3]), 32'd0);
        chk("abort_busy", 32'(o_busy[3]), 32'd0);
        chk("abort_cmd_err", 32'(o_err[3]), 32'd0);
        chk("abort_rdata_i0", o_rdata[0], 32'd0);
        wr[3] = 1'b0;
        rd[3] = 1'b1;
        @(posedge clk); #1;
        chk("rst_ignores_req", 32'(o_busy[3]), 32'd0);
        rd[3] = 1'b0;
        for (int i = 0; i < NI; i++) last_rd[i] = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(3, 1'b1, 1'b0, 32'h9, 32'h0, 0);
        do_access(0, 1'b0, 1'b1, 32'h7, 32'h7777_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
